phy_rx_sync_ctrl: RTL
=====================

// Module: phy_rx_sync_ctrl
// PURPOSE
//  Per-lane receive synchronisation controller for the PHY RX path, in the clk_32f domain.
//  - Shifts in one serial bit per cycle, MSB first.
//  - Hunts for the comma byte 0xBC and locks byte alignment.
//  - Requires BC_REQ consecutive commas before declaring the lane active.
//  - Then delivers data bytes and drops commas as idle.
//  - Sits between the lane serial input and the downstream byte/word consumers.
// PARAMETERS
//  BC_REQ     4      consecutive aligned commas (including the first) needed to reach ACTIVE; legal range 1..15
//  COMMA      8'hBC  alignment/idle character
// PORTS
//  clk_32f     in   1   bit clock; all logic on the rising edge
//  reset       in   1   asynchronous, active-high reset
//  en          in   1   lane enable; 0 forces SEARCH (synchronous)
//  ser_in      in   1   serial data, one bit per clk_32f, MSB first
//  active      out  1   lane in ACTIVE state
//  byte_out    out  8   last completed data byte
//  byte_valid  out  1   one-cycle pulse; byte_out is a new data byte
//  word_out    out  32  assembled word (PHY_RX_WORD_EN only)
//  word_valid  out  1   one-cycle pulse; word_out is valid (PHY_RX_WORD_EN only)
// BEHAVIOUR
//  - Reset values: all outputs 0; sr=0; bit_cnt=0; bc_cnt=0; state=SEARCH.
//  - Shift register: nsr = {sr[6:0], ser_in}; sr <= nsr every cycle in every state.
//  - SEARCH (bit-level hunt):
//    - If en && nsr==COMMA: bit_cnt<=0, bc_cnt<=1, go INIT.
//    - If BC_REQ==1, go straight to ACTIVE instead.
//  - Byte boundary: in INIT/ACTIVE, bit_cnt increments 0..7 and wraps to 0.
//    - bit_cnt==7 marks a byte boundary; the completed byte is nsr.
//  - INIT, at each byte boundary:
//    - nsr==COMMA: bc_cnt++; when the incremented count reaches BC_REQ, go ACTIVE.
//    - nsr!=COMMA: bc_cnt<=0, go SEARCH. No bytes are delivered in INIT.
//  - ACTIVE, at each byte boundary:
//    - nsr!=COMMA: byte_out<=nsr and byte_valid<=1 for one cycle.
//    - nsr==COMMA: idle; byte_out holds its value and byte_valid stays 0.
//  - Latency: byte_valid rises on the clock edge that samples the byte's LSB (the bit_cnt==7 edge) and is high for the following cycle.
//  - active is registered: 1 from the cycle after the ACTIVE transition edge.
//  - Exit:
//    - en==0 in any state: next state SEARCH, bc_cnt<=0, bit_cnt<=0.
//    - Any pending byte_valid/word_valid pulse is suppressed.
//    - active drops on the following cycle.
//  - Reset mid-operation: immediate return to reset values; alignment is lost and must be reacquired.
//  - Simultaneous events: en==0 has priority over comma detection and over byte delivery in the same cycle.
//  - Comma inside data: a data stream that happens to contain 0xBC at a byte boundary is treated as idle (by design).
//  - Pulses: byte_valid and word_valid never stay high for two consecutive cycles (minimum byte spacing is 8 cycles).
// CONFIGURATION
//  PHY_RX_WORD_EN defined:
//    - Data bytes are packed into word_out; the first byte goes to [31:24], the fourth to [7:0].
//    - A 2-bit byte index advances only on delivered data bytes; commas do not advance it.
//    - word_valid pulses on the cycle after the 4th byte's byte_valid pulse.
//    - A partial word is discarded on leaving ACTIVE, on en==0 and on reset.
//  PHY_RX_WORD_EN undefined:
//    - word_out is tied to 32'h0 and word_valid to 0; no packing logic is built.
//    - The ports remain present.
// STRUCTURE
//  - Package phy_rx_pkg:
//    - COMMA_BC = 8'hBC.
//    - State encoding: SEARCH=2'd0, INIT=2'd1, ACTIVE=2'd2.
//    - Byte width 8 and word width 32.
//  - Sub-module phy_rx_word_pack (PHY_RX_WORD_EN only):
//    - Inputs: byte_out/byte_valid and a flush (= !active || !en).
//    - Outputs: word_out/word_valid.
//  - The FSM, shift register and counters stay in phy_rx_sync_ctrl.
// TESTING
//  - Reset: assert reset mid-stream (async, between edges) -> all outputs 0 immediately; active=0 until 4 new BCs are received.
//  - Lock:
//    - Stimulus: 3 noise bits, then BC,BC,BC,BC (10111100 x4), then 0xC3.
//    - Response: active=1 after the 4th BC; byte_valid pulse with byte_out=8'hC3; no pulses during the BCs.
//  - Aborted init: BC,BC,0x55,BC -> back to SEARCH at the 0x55 boundary, active stays 0; rehunt locks on the last BC with bc_cnt=1.
//  - Idle filtering: in ACTIVE send 0x1E,BC,BC,0xFF -> exactly two byte_valid pulses (0x1E then 0xFF), 24 cycles apart.
//  - Enable drop: deassert en during the LSB cycle of a data byte -> no byte_valid pulse; active=0 next cycle; SEARCH.
//  - PHY_RX_WORD_EN: ACTIVE, send 0x12,BC,0x34,0x56,0x78 -> one word_valid with word_out=32'h12345678.
//    - With the macro undefined: word_valid stays 0 for the same stimulus.

Source files
------------

// File: rtl/phy_rx_sync_ctrl_pkg.sv
// Shared types and constants for the PHY RX lane synchronisation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package phy_rx_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  // Alignment / idle character.
  localparam logic [BYTE_W-1:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    INIT   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// Lane-side bundle for phy_rx_sync_ctrl: enable and serial in, lock status and byte/word out.
// Latency: n/a (wiring only).
// Backpressure: none; consumers must take every byte_valid/word_valid pulse.
//
// Signals: en, ser_in (towards the controller); active, byte_out, byte_valid,
//          word_out, word_valid (from the controller).
// The master modport is the lane/consumer side, the slave modport is the controller.
interface phy_rx_sync_ctrl_if;
  import phy_rx_pkg::*;

  logic              en;
  logic              ser_in;
  logic              active;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;

  modport master (
    output en, ser_in,
    input  active, byte_out, byte_valid, word_out, word_valid
  );

  modport slave (
    input  en, ser_in,
    output active, byte_out, byte_valid, word_out, word_valid
  );

endinterface

// File: rtl/phy_rx_sync_ctrl_word_pack.sv
// Packs delivered data bytes into 32-bit words, first byte in [31:24].
// Latency: word_valid one cycle after the 4th byte's byte_valid.
// Backpressure: none; a flush drops any partial word.
//
// Ports: clk_32f, reset (async, active high); byte_out_i/byte_valid_i delivered bytes;
//        flush_i discards a partial word; word_out_o/word_valid_o assembled word and pulse.
// Only built when PHY_RX_WORD_EN is defined.
`ifdef PHY_RX_WORD_EN
module phy_rx_word_pack
  import phy_rx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_out_i,
  input  logic              byte_valid_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] word_out_o,
  output logic              word_valid_o
);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      idx_q        <= 2'd0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (flush_i) begin
        idx_q  <= 2'd0;
        word_q <= '0;
      end else if (byte_valid_i) begin
        case (idx_q)
          2'd0:    word_q[31:24] <= byte_out_i;
          2'd1:    word_q[23:16] <= byte_out_i;
          2'd2:    word_q[15:8]  <= byte_out_i;
          default: word_q[7:0]   <= byte_out_i;
        endcase
        idx_q        <= idx_q + 2'd1;
        word_valid_q <= (idx_q == 2'd3);
      end
    end
  end

  assign word_out_o   = word_q;
  assign word_valid_o = word_valid_q;

endmodule
`endif

// File: rtl/phy_rx_sync_ctrl.sv
// Per-lane RX sync: bit hunt for the comma, BC_REQ-comma lock, then byte delivery with comma idles dropped.
// Latency: byte_valid high the cycle after the edge sampling the byte's LSB; word_valid one cycle later.
// Backpressure: none; the serial stream cannot be stalled, pulses are at least 8 cycles apart.
//
// Ports: clk_32f bit clock, reset async active-high, rx (slave modport) carrying
//        en, ser_in, active, byte_out, byte_valid, word_out, word_valid.
// Macro PHY_RX_WORD_EN builds the word packer; otherwise word_out=0 and word_valid=0.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter int                BC_REQ = 4,        // 1..15
  parameter logic [BYTE_W-1:0] COMMA  = COMMA_BC
) (
  input  logic               clk_32f,
  input  logic               reset,
  phy_rx_sync_ctrl_if.slave  rx
);

  localparam logic [3:0] BC_REQ_L = 4'(BC_REQ);

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] sr_q, nsr;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        bc_cnt_q, bc_cnt_d;
  logic [BYTE_W-1:0] byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic              active_q;
  logic              boundary;

  // The byte being completed this cycle includes the incoming bit.
  assign nsr      = {sr_q[BYTE_W-2:0], rx.ser_in};
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bc_cnt_d     = bc_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;

    // Enable low overrides comma detection and delivery in the same cycle.
    if (!rx.en) begin
      state_d   = SEARCH;
      bit_cnt_d = 3'd0;
      bc_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (nsr == COMMA) begin
            bit_cnt_d = 3'd0;
            bc_cnt_d  = 4'd1;
            state_d   = (BC_REQ_L == 4'd1) ? ACTIVE : INIT;
          end
        end
        INIT: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (boundary) begin
            if (nsr == COMMA) begin
              bc_cnt_d = bc_cnt_q + 4'd1;
              if (bc_cnt_d == BC_REQ_L) state_d = ACTIVE;
            end else begin
              bc_cnt_d = 4'd0;
              state_d  = SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          // Commas at a byte boundary are idle fill, even inside a data run.
          if (boundary && (nsr != COMMA)) begin
            byte_out_d   = nsr;
            byte_valid_d = 1'b1;
          end
        end
        default: begin
          state_d   = SEARCH;
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      sr_q         <= '0;
      bit_cnt_q    <= 3'd0;
      bc_cnt_q     <= 4'd0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= nsr;
      bit_cnt_q    <= bit_cnt_d;
      bc_cnt_q     <= bc_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      active_q     <= (state_d == ACTIVE);
    end
  end

  assign rx.active     = active_q;
  assign rx.byte_out   = byte_out_q;
  assign rx.byte_valid = byte_valid_q;

`ifdef PHY_RX_WORD_EN
  logic [WORD_W-1:0] word_out;
  logic              word_valid;

  phy_rx_word_pack u_word_pack (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .byte_out_i   (byte_out_q),
    .byte_valid_i (byte_valid_q),
    .flush_i      (!active_q || !rx.en),
    .word_out_o   (word_out),
    .word_valid_o (word_valid)
  );

  assign rx.word_out   = word_out;
  assign rx.word_valid = word_valid;
`else
  assign rx.word_out   = '0;
  assign rx.word_valid = 1'b0;
`endif

endmodule
